// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants and the line/frame total calculation
// shared by the timing generator and its sync delay line.
package vga_timing_pkg;

  localparam int POS_W = 10;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_SYNC_POL  = 0;

  typedef struct packed {
    logic hsync;
    logic vsync;
  } sync_pair_t;

  function automatic int calc_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  localparam int DEF_H_TOTAL = calc_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int DEF_V_TOTAL = calc_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift line for the sync pair; every stage shifts on every clock
// and resets to the supplied inactive level.
module vga_sync_delay #(
  parameter int               WIDTH       = 2,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] sync_out
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] q_reg;
      logic [WIDTH-1:0] q_next;

      if (gi == 0) begin : g_first
        assign q_next = sync_in;
      end else begin : g_rest
        assign q_next = g_stage[gi-1].q_reg;
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          q_reg <= RESET_VALUE;
        end else begin
          q_reg <= q_next;
        end
      end
    end
  endgenerate

  assign sync_out = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing: position counters plus registered visible/strobe/sync flags
// aligned to the position. Define VGA_TIMING_SYNC_DELAY_EN to delay the syncs.
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int SYNC_POL   = DEF_SYNC_POL,
  parameter int SYNC_DELAY = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  output logic [POS_W-1:0] o_hpos,
  output logic [POS_W-1:0] o_vpos,
  output logic             o_visible,
  output logic             o_line_strobe,
  output logic             o_frame_strobe,
  output logic             o_hsync,
  output logic             o_vsync
);

  localparam int H_TOTAL = calc_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = calc_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [POS_W-1:0] H_LAST       = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST       = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] H_VIS_END    = POS_W'(H_VISIBLE);
  localparam logic [POS_W-1:0] V_VIS_END    = POS_W'(V_VISIBLE);
  localparam logic [POS_W-1:0] H_SYNC_START = POS_W'(H_VISIBLE + H_FRONT);
  localparam logic [POS_W-1:0] H_SYNC_END   = POS_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [POS_W-1:0] V_SYNC_START = POS_W'(V_VISIBLE + V_FRONT);
  localparam logic [POS_W-1:0] V_SYNC_END   = POS_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic             SYNC_ACT     = (SYNC_POL != 0);

  generate
    if (SYNC_DELAY < 1 || SYNC_DELAY > 4) begin : g_sync_delay_range
      $error("SYNC_DELAY must be within 1..4");
    end
  endgenerate

  logic [POS_W-1:0] hpos_reg, hpos_next;
  logic [POS_W-1:0] vpos_reg, vpos_next;
  logic             visible_reg, visible_next;
  logic             line_strobe_reg, line_strobe_next;
  logic             frame_strobe_reg, frame_strobe_next;
  sync_pair_t       sync_reg, sync_next;

  // Flags are derived from the next position so they land in the same cycle as it.
  always_comb begin
    hpos_next = hpos_reg;
    vpos_next = vpos_reg;
    if (i_enable) begin
      if (hpos_reg == H_LAST) begin
        hpos_next = '0;
        vpos_next = (vpos_reg == V_LAST) ? '0 : vpos_reg + 1'b1;
      end else begin
        hpos_next = hpos_reg + 1'b1;
      end
    end

    line_strobe_next  = i_enable && (hpos_next == '0);
    frame_strobe_next = line_strobe_next && (vpos_next == V_VIS_END);
    visible_next      = (hpos_next < H_VIS_END) && (vpos_next < V_VIS_END);
    sync_next.hsync   = ((hpos_next >= H_SYNC_START) && (hpos_next < H_SYNC_END)) ? SYNC_ACT : ~SYNC_ACT;
    sync_next.vsync   = ((vpos_next >= V_SYNC_START) && (vpos_next < V_SYNC_END)) ? SYNC_ACT : ~SYNC_ACT;
  end

  // Reset parks on the last pixel so the first enabled edge presents (0,0).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hpos_reg         <= H_LAST;
      vpos_reg         <= V_LAST;
      visible_reg      <= 1'b0;
      line_strobe_reg  <= 1'b0;
      frame_strobe_reg <= 1'b0;
      sync_reg         <= {~SYNC_ACT, ~SYNC_ACT};
    end else begin
      hpos_reg         <= hpos_next;
      vpos_reg         <= vpos_next;
      visible_reg      <= visible_next;
      line_strobe_reg  <= line_strobe_next;
      frame_strobe_reg <= frame_strobe_next;
      sync_reg         <= sync_next;
    end
  end

  assign o_hpos         = hpos_reg;
  assign o_vpos         = vpos_reg;
  assign o_visible      = visible_reg;
  assign o_line_strobe  = line_strobe_reg;
  assign o_frame_strobe = frame_strobe_reg;

`ifdef VGA_TIMING_SYNC_DELAY_EN
  sync_pair_t sync_dly;

  vga_sync_delay #(
    .WIDTH       (2),
    .DEPTH       (SYNC_DELAY),
    .RESET_VALUE ({~SYNC_ACT, ~SYNC_ACT})
  ) u_sync_delay (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .sync_in  (sync_reg),
    .sync_out (sync_dly)
  );

  assign o_hsync = sync_dly.hsync;
  assign o_vsync = sync_dly.vsync;
`else
  assign o_hsync = sync_reg.hsync;
  assign o_vsync = sync_reg.vsync;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: default horizontal timing with a short
// 11-line frame, checked every cycle against a raster-index model.
module tb_vga_timing_generator;

  localparam int HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int VV = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int SD = 2;
`ifdef VGA_TIMING_SYNC_DELAY_EN
  localparam int LAG = SD;
`else
  localparam int LAG = 0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_enable;
  logic [9:0] o_hpos, o_vpos;
  logic       o_visible, o_line_strobe, o_frame_strobe, o_hsync, o_vsync;

  vga_timing_generator #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(0), .SYNC_DELAY(SD)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_enable       (i_enable),
    .o_hpos         (o_hpos),
    .o_vpos         (o_vpos),
    .o_visible      (o_visible),
    .o_line_strobe  (o_line_strobe),
    .o_frame_strobe (o_frame_strobe),
    .o_hsync        (o_hsync),
    .o_vsync        (o_vsync)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int passes = 0;

  // Model: count of enabled edges since reset, mapped onto a raster index.
  int         m_n;
  bit         m_en_last;
  logic [1:0] m_hist [4];

  function automatic int pidx(input int n);
    return (FRAME - 1 + n) % FRAME;
  endfunction

  function automatic logic [1:0] aligned_sync(input int n);
    int h, v;
    h = pidx(n) % HT;
    v = pidx(n) / HT;
    return {~((h >= HV + HF) && (h < HV + HF + HS)), ~((v >= VV + VF) && (v < VV + VF + VS))};
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_n       <= 0;
      m_en_last <= 1'b0;
      for (int i = 0; i < 4; i++) m_hist[i] <= 2'b11;
    end else begin
      for (int i = 3; i > 0; i--) m_hist[i] <= m_hist[i-1];
      m_hist[0] <= aligned_sync(m_n);
      m_en_last <= i_enable;
      if (i_enable) m_n <= (m_n + 1) % FRAME;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  task automatic compare_cycle();
    int e_h, e_v;
    logic e_vis, e_ls, e_fs;
    logic [1:0] e_sync;
    logic [24:0] exp_v, act_v;
    e_h    = pidx(m_n) % HT;
    e_v    = pidx(m_n) / HT;
    e_vis  = (e_h < HV) && (e_v < VV);
    e_ls   = m_en_last && (e_h == 0);
    e_fs   = e_ls && (e_v == VV);
    e_sync = (LAG == 0) ? aligned_sync(m_n) : m_hist[(LAG > 0) ? LAG - 1 : 0];
    exp_v  = {10'(e_h), 10'(e_v), e_vis, e_ls, e_fs, e_sync};
    act_v  = {o_hpos, o_vpos, o_visible, o_line_strobe, o_frame_strobe, o_hsync, o_vsync};
    checks++;
    if (act_v == exp_v) passes++;
    else $display("FAIL cycle: got h=%0d v=%0d vis/ls/fs/hs/vs=%05b expected h=%0d v=%0d vis/ls/fs/hs/vs=%05b at t=%0t",
                  o_hpos, o_vpos, act_v[4:0], e_h, e_v, exp_v[4:0], $time);
  endtask

  task automatic tick();
    @(negedge i_clk);
    compare_cycle();
  endtask

  task automatic drive(input logic rst_n, input logic en);
    #2;
    i_rst_n  = rst_n;
    i_enable = en;
  endtask

  task automatic wait_pos(input int h, input int v, input int limit);
    int n = 0;
    while (!((o_hpos == 10'(h)) && (v < 0 || o_vpos == 10'(v))) && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (n < limit) passes++;
    else $display("FAIL wait_pos: got timeout after %0d cycles expected reach (%0d,%0d)", n, h, v);
  endtask

  initial begin
    int ls_cnt, hs_low, hs_first, hs_last, vis_cnt, vs_low, vs_first_h, vs_first_v, fs_cnt;
    int fs_at [2];
    ls_cnt = 0; hs_low = 0; hs_first = -1; hs_last = -1;
    vis_cnt = 0; vs_low = 0; vs_first_h = -1; vs_first_v = -1; fs_cnt = 0;
    fs_at[0] = 0; fs_at[1] = 0;

    i_rst_n  = 1'b1;
    i_enable = 1'b0;
    #1 i_rst_n = 1'b0;
    #1;
    chk("rst_hpos", o_hpos, 799);
    chk("rst_vpos", o_vpos, 10);
    chk("rst_visible", o_visible, 0);
    chk("rst_hsync", o_hsync, 1);
    chk("rst_vsync", o_vsync, 1);
    chk("rst_strobes", {o_line_strobe, o_frame_strobe}, 0);
    repeat (3) tick();
    drive(1'b1, 1'b1);

    for (int k = 1; k <= 2 * FRAME + 1; k++) begin
      tick();
      if (k == 1) begin
        chk("first_hpos", o_hpos, 0);
        chk("first_vpos", o_vpos, 0);
        chk("first_visible", o_visible, 1);
        chk("first_line_strobe", o_line_strobe, 1);
      end
      if (k <= HT) begin
        ls_cnt += int'(o_line_strobe);
        if (!o_hsync) begin
          hs_low++;
          if (hs_first < 0) hs_first = int'(o_hpos);
          hs_last = int'(o_hpos);
        end
      end
      if (k == HT + 1) begin
        chk("line2_hpos", o_hpos, 0);
        chk("line2_vpos", o_vpos, 1);
        chk("line2_strobe", o_line_strobe, 1);
      end
      if (k <= FRAME) begin
        vis_cnt += int'(o_visible);
        if (!o_vsync) begin
          vs_low++;
          if (vs_first_h < 0) begin
            vs_first_h = int'(o_hpos);
            vs_first_v = int'(o_vpos);
          end
        end
      end
      if (o_frame_strobe) begin
        if (fs_cnt < 2) fs_at[fs_cnt] = k;
        fs_cnt++;
        chk("fs_hpos", o_hpos, 0);
        chk("fs_vpos", o_vpos, VV);
      end
      if (k == FRAME + 1) begin
        chk("wrap_hpos", o_hpos, 0);
        chk("wrap_vpos", o_vpos, 0);
        chk("wrap_line_strobe", o_line_strobe, 1);
      end
    end
    chk("line_strobes_per_line", ls_cnt, 1);
    chk("hsync_low_count", hs_low, 96);
    chk("hsync_first_low", hs_first, 656 + LAG);
    chk("hsync_last_low", hs_last, 751 + LAG);
    chk("visible_per_frame", vis_cnt, HV * VV);
    chk("vsync_low_count", vs_low, VS * HT);
    chk("vsync_first_h", vs_first_h, LAG);
    chk("vsync_first_v", vs_first_v, 7);
    chk("frame_strobe_count", fs_cnt, 2);
    chk("frame_strobe_first", fs_at[0], 6 * HT + 1);
    chk("frame_strobe_period", fs_at[1] - fs_at[0], FRAME);

    // Pause mid-line: everything holds, then resumes at the next column.
    wait_pos(100, -1, FRAME);
    drive(1'b1, 1'b0);
    repeat (5) begin
      tick();
      chk("pause_hpos", o_hpos, 100);
      chk("pause_strobe", o_line_strobe, 0);
    end
    drive(1'b1, 1'b1);
    tick();
    chk("resume_hpos", o_hpos, 101);

    // Pause on a line start: the strobe must not refire on resume.
    wait_pos(0, -1, FRAME);
    drive(1'b1, 1'b0);
    repeat (2) tick();
    chk("hold0_strobe", o_line_strobe, 0);
    drive(1'b1, 1'b1);
    tick();
    chk("resume0_hpos", o_hpos, 1);
    chk("resume0_strobe", o_line_strobe, 0);

    // Asynchronous reset mid-frame.
    wait_pos(300, 3, 2 * FRAME);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_hpos", o_hpos, 799);
    chk("mid_rst_vpos", o_vpos, 10);
    chk("mid_rst_visible", o_visible, 0);
    chk("mid_rst_syncs", {o_hsync, o_vsync}, 3);
    chk("mid_rst_strobes", {o_line_strobe, o_frame_strobe}, 0);
    repeat (2) tick();
    drive(1'b1, 1'b1);
    tick();
    chk("post_rst_hpos", o_hpos, 0);
    chk("post_rst_vpos", o_vpos, 0);
    chk("post_rst_strobe", o_line_strobe, 1);
    repeat (20) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
